div_sequencer: RTL and testbench

- Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU), replacing the single-cycle combinational divider in the core ALU.
- Accepts one request at a time via a start/busy/done handshake.
- Runs a radix-2 restoring divide over WIDTH iterations, applies sign fix-up, and returns a registered result.
- The core stalls its PC/writeback while busy is high.

---
 rtl/div_sequencer.sv | 179 +++++++++++++++++
 tb/tb_div_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with a start/busy/done handshake.
// Divide-by-zero and signed overflow finish straight from IDLE; other requests take WIDTH iterations plus a sign fix-up cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;

  // Request decode, evaluated against the raw input operands
  logic             op_signed;
  logic             op_rem;
  logic             accept;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH-1:0] special_value;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // One restoring iteration
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] fixed_value;

  assign op_signed = ~funct3[0];
  assign op_rem    = funct3[1];
  assign accept    = start && (state == IDLE) && funct3[2] && !flush;
  assign div_zero  = (divisor == '0);
  assign overflow  = op_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign special   = div_zero || overflow;
  assign mag_a     = (op_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign mag_b     = (op_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  always_comb begin
    special_value = '0;
    if (div_zero) begin
      special_value = op_rem ? dividend : '1;
    end else begin
      // Signed overflow: quotient is the dividend itself, remainder is zero
      special_value = op_rem ? '0 : dividend;
    end
  end

  // The shifted remainder is below twice the divisor, so a non-negative trial fits WIDTH bits
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs};
  assign trial_ok = ~trial[WIDTH+1];
  assign rem_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], trial_ok};

  always_comb begin
    fixed_value = '0;
    if (is_rem) begin
      fixed_value = neg_r ? (~rem + 1'b1) : rem;
    end else begin
      fixed_value = neg_q ? (~quo + 1'b1) : quo;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !special) state_next = CALC;
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == CW'(WIDTH-1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand capture, iteration, fix-up and result/done registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (special) begin
              result <= special_value;
              done   <= 1'b1;
            end else begin
              rem    <= '0;
              quo    <= mag_a;
              dvs    <= mag_b;
              cnt    <= '0;
              neg_q  <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r  <= op_signed && dividend[WIDTH-1];
              is_rem <= op_rem;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            result <= fixed_value;
            done   <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_total;
  int          n_pass;
  logic [31:0] last_result;

  div_sequencer #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .funct3   (funct3),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: RISC-V M-extension divide semantics using plain arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Issues one request, optionally pokes a start while busy, and returns in the done cycle
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] exp;
    bit          sp;
    int          cyc;
    int          bcnt;
    exp = model(f3, a, b);
    sp  = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    funct3 = f3; dividend = a; divisor = b; start = 1'b1;
    step();
    start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      if (cyc == poke) begin
        start = 1'b1; funct3 = 3'b101; dividend = 32'd1000; divisor = 32'd1;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    check($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), 32'(cyc), sp ? 32'd1 : 32'd34);
    check("busy_cycles", 32'(bcnt), sp ? 32'd0 : 32'd33);
    check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result, exp);
    last_result = exp;
  endtask

  task automatic done_drops();
    step();
    check("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic no_done_for(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    check("quiet_no_done_no_busy", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    n_total = 0;
    n_pass  = 0;
    last_result = 32'd0;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; dividend = 32'd0; divisor = 32'd0;
    step();
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset_n = 1'b1;
    step();

    // Unsigned and signed normal path
    do_op(3'b101, 32'd100, 32'd7, 0);
    check("divu_100_7_const", result, 32'd14);
    done_drops();
    do_op(3'b111, 32'd100, 32'd7, 0);
    check("remu_100_7_const", result, 32'd2);
    done_drops();
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2_const", result, 32'hFFFF_FFFD);
    done_drops();
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    check("rem_m7_2_const", result, 32'hFFFF_FFFF);
    done_drops();
    do_op(3'b110, 32'd7, 32'hFFFF_FFFE, 0);
    check("rem_7_m2_const", result, 32'd1);
    done_drops();

    // Special cases resolved at acceptance
    do_op(3'b101, 32'd5, 32'd0, 0);
    done_drops();
    do_op(3'b110, 32'd5, 32'd0, 0);
    check("rem_5_0_const", result, 32'd5);
    done_drops();
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_const", result, 32'h8000_0000);
    done_drops();
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    done_drops();

    // Start while busy is ignored; start in the done cycle is accepted back-to-back
    do_op(3'b100, 32'd100, 32'd3, 10);
    check("div_100_3_const", result, 32'd33);
    do_op(3'b101, 32'd200, 32'd9, 0);
    check("back_to_back_const", result, 32'd22);
    done_drops();

    // Flush mid-operation
    funct3 = 3'b101; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 15; i++) step();
    check("busy_before_flush", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("busy_after_flush", {31'd0, busy}, 32'd0);
    no_done_for(40);
    check("result_kept_after_flush", result, last_result);

    // Reset mid-operation
    funct3 = 3'b100; dividend = 32'd12345; divisor = 32'd17; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 20; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    last_result = 32'd0;
    check("midop_reset_busy", {31'd0, busy}, 32'd0);
    check("midop_reset_done", {31'd0, done}, 32'd0);
    check("midop_reset_result", result, 32'd0);
    no_done_for(40);

    // Ignored requests: non-divide funct3, and start together with flush
    funct3 = 3'b000; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    no_done_for(5);
    funct3 = 3'b101; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    no_done_for(40);
    check("result_kept_after_ignored", result, last_result);

    // Randomized operations
    for (int k = 0; k < 30; k++) begin
      rf3 = 3'(4 + $urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
      else if (sel == 3) rb = 32'($urandom_range(0, 40)) - 32'd20;
      do_op(rf3, ra, rb, (sel == 4) ? 7 : 0);
      done_drops();
      for (int j = 0; j < $urandom_range(0, 2); j++) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
